// File: rtl/univ_shift_reg_xfer.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg_xfer
// Description : Parametrised universal shift register with a serial-transfer
//               engine. While idle, the register performs hold, shift,
//               rotate, parallel load or clear, selected by a mode code.
//               A one-shot start loads a word and serialises it over WIDTH
//               cycles. A busy/done handshake frames the transfer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     register width in bits (must be >= 2)
//   LSB_FIRST 1: transfer shifts right, LSB out first
//             0: transfer shifts left, MSB out first
//   CNT_W     bit-counter width, derived from WIDTH (not overridable)
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous, active-high reset
//   mode      in   [2:0] register operation while idle
//   par_in    in   [WIDTH-1:0] parallel data for load and start
//   ser_in_l  in   serial bit entering the MSB on a right shift
//   ser_in_r  in   serial bit entering the LSB on a left shift
//   start     in   single-cycle request to load par_in and serialise it
//   par_out   out  [WIDTH-1:0] register contents (registered)
//   ser_out   out  serial output bit (combinational from the register)
//   busy      out  high while a transfer is in progress
//   done      out  one-cycle pulse after the last transfer bit
//   bit_cnt   out  [CNT_W-1:0] index of the bit on ser_out during a
//                  transfer, otherwise 0
// ============================================================================
module univ_shift_reg_xfer #(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b1,
  localparam int  CNT_W     = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  // --------------------------------------------------------------------------
  // Mode encoding (applies only while idle and start is low)
  // --------------------------------------------------------------------------
  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_SHR    = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_LOAD   = 3'b011;
  localparam logic [2:0] MODE_ROTR   = 3'b100;
  localparam logic [2:0] MODE_ROTL   = 3'b101;
  localparam logic [2:0] MODE_CLEAR  = 3'b110;
  // 3'b111 is reserved and decodes as hold through the default branch.

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reg_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Candidate register values for each operation.
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] rotr_val;
  logic [WIDTH-1:0] rotl_val;
  logic [WIDTH-1:0] xfer_val;

  assign shr_val  = {ser_in_l, par_out[WIDTH-1:1]};
  assign shl_val  = {par_out[WIDTH-2:0], ser_in_r};
  assign rotr_val = {par_out[0], par_out[WIDTH-1:1]};
  assign rotl_val = {par_out[WIDTH-2:0], par_out[WIDTH-1]};

  // --------------------------------------------------------------------------
  // Transfer direction: the serial output is always the bit that the next
  // transfer shift pushes out, so ser_out and the shift must agree.
  // --------------------------------------------------------------------------
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign xfer_val = shr_val;
      assign ser_out  = par_out[0];
    end else begin : g_msb_first
      assign xfer_val = shl_val;
      assign ser_out  = par_out[WIDTH-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    reg_nxt   = par_out;
    cnt_nxt   = bit_cnt;
    busy_nxt  = busy;
    // done is a pulse: it is cleared on every edge that does not set it.
    done_nxt  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          // start has priority over any mode operation.
          state_nxt = ST_XFER;
          reg_nxt   = par_in;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end else begin
          case (mode)
            MODE_HOLD:  reg_nxt = par_out;
            MODE_SHR:   reg_nxt = shr_val;
            MODE_SHL:   reg_nxt = shl_val;
            MODE_LOAD:  reg_nxt = par_in;
            MODE_ROTR:  reg_nxt = rotr_val;
            MODE_ROTL:  reg_nxt = rotl_val;
            MODE_CLEAR: reg_nxt = '0;
            default:    reg_nxt = par_out;
          endcase
        end
      end

      ST_XFER: begin
        // mode and start are deliberately ignored for the whole transfer.
        if (bit_cnt == LAST_BIT) begin
          // The last bit has been on ser_out for a full cycle; the register
          // keeps its final value rather than shifting once more.
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          reg_nxt = xfer_val;
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. Reset is asynchronous so that a transfer is
  // abandoned immediately, with no trailing done pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      par_out <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      par_out <= reg_nxt;
      bit_cnt <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg_xfer
// Description : Scoreboard bench for univ_shift_reg_xfer. Two instances
//               (LSB-first and MSB-first) share one stimulus stream. A
//               behavioural model predicts every cycle's outputs into a
//               queue, and a monitor pops and compares them after each
//               clock edge and after each reset assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg_xfer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] par_in = '0;
  logic         ser_in_l = 1'b0;
  logic         ser_in_r = 1'b0;
  logic         start = 1'b0;

  logic [W-1:0] po_l, po_m;
  logic         so_l, so_m, busy_l, busy_m, done_l, done_m;
  logic [2:0]   cnt_l, cnt_m;

  always #5 clk = ~clk;

  univ_shift_reg_xfer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .CLK(clk), .RST(rst), .mode(mode), .par_in(par_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start),
    .par_out(po_l), .ser_out(so_l), .busy(busy_l), .done(done_l),
    .bit_cnt(cnt_l)
  );

  univ_shift_reg_xfer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .CLK(clk), .RST(rst), .mode(mode), .par_in(par_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start),
    .par_out(po_m), .ser_out(so_m), .busy(busy_m), .done(done_m),
    .bit_cnt(cnt_m)
  );

  typedef struct packed {
    logic [W-1:0] po;
    logic         so;
    logic         busy;
    logic         done;
    logic [2:0]   cnt;
  } exp_t;

  // Index 1 = LSB-first instance, index 0 = MSB-first instance.
  exp_t [1:0] sb_q[$];

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Behavioural model: register value, position in the transfer (-1 = idle),
  // the word being sent, and the done flag.
  // --------------------------------------------------------------------------
  logic [W-1:0] m_reg  [2];
  logic [W-1:0] m_word [2];
  int           m_idx  [2];
  logic         m_done [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_reg[d] = '0; m_word[d] = '0; m_idx[d] = -1; m_done[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    bit lsb;
    lsb = (d == 1);
    if (m_idx[d] < 0) begin
      m_done[d] = 1'b0;
      if (start) begin
        m_reg[d] = par_in; m_word[d] = par_in; m_idx[d] = 0;
      end else begin
        case (mode)
          3'd1: m_reg[d] = (m_reg[d] >> 1) | (W'(ser_in_l) << (W-1));
          3'd2: m_reg[d] = (m_reg[d] << 1) | W'(ser_in_r);
          3'd3: m_reg[d] = par_in;
          3'd4: m_reg[d] = (m_reg[d] >> 1) | (m_reg[d] << (W-1));
          3'd5: m_reg[d] = (m_reg[d] << 1) | (m_reg[d] >> (W-1));
          3'd6: m_reg[d] = '0;
          default: ;
        endcase
      end
    end else if (m_idx[d] == W-1) begin
      m_idx[d] = -1; m_done[d] = 1'b1;
    end else begin
      m_done[d] = 1'b0;
      if (lsb) m_reg[d] = (m_reg[d] >> 1) | (W'(ser_in_l) << (W-1));
      else     m_reg[d] = (m_reg[d] << 1) | W'(ser_in_r);
      m_idx[d]++;
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    bit   lsb;
    lsb    = (d == 1);
    e.po   = m_reg[d];
    e.busy = (m_idx[d] >= 0);
    e.done = m_done[d];
    e.cnt  = e.busy ? 3'(m_idx[d]) : 3'd0;
    // During a transfer the serial bit is taken from the original word.
    if (e.busy) e.so = lsb ? m_word[d][m_idx[d]] : m_word[d][W-1-m_idx[d]];
    else        e.so = lsb ? m_reg[d][0] : m_reg[d][W-1];
    return e;
  endfunction

  function automatic exp_t [1:0] model_pair();
    exp_t [1:0] p;
    p[1] = model_out(1);
    p[0] = model_out(0);
    return p;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step(input logic s, input logic [2:0] md, input logic [W-1:0] pi,
                      input logic sl, input logic sr);
    @(negedge clk);
    start = s; mode = md; par_in = pi; ser_in_l = sl; ser_in_r = sr;
    model_edge(1);
    model_edge(0);
    sb_q.push_back(model_pair());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: one expectation for the reset edge itself,
  // one for the clock edge seen while reset is still high.
  task automatic pulse_reset();
    @(negedge clk);
    start = 1'b0; mode = 3'b000;
    model_reset();
    sb_q.push_back(model_pair());
    sb_q.push_back(model_pair());
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always begin
    exp_t [1:0] e;
    @(posedge clk or posedge rst);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("lsb.par_out", int'(po_l),   int'(e[1].po));
      cmp("lsb.ser_out", int'(so_l),   int'(e[1].so));
      cmp("lsb.busy",    int'(busy_l), int'(e[1].busy));
      cmp("lsb.done",    int'(done_l), int'(e[1].done));
      cmp("lsb.bit_cnt", int'(cnt_l),  int'(e[1].cnt));
      cmp("msb.par_out", int'(po_m),   int'(e[0].po));
      cmp("msb.ser_out", int'(so_m),   int'(e[0].so));
      cmp("msb.busy",    int'(busy_m), int'(e[0].busy));
      cmp("msb.done",    int'(done_m), int'(e[0].done));
      cmp("msb.bit_cnt", int'(cnt_m),  int'(e[0].cnt));
    end
  end

  // Hard time limit in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    model_reset();
    pulse_reset();
    idle_steps(1);

    // Reset in the middle of a transfer (bit_cnt = 3): no done afterwards.
    step(1'b1, 3'b000, 8'hC3, 1'b0, 1'b0);
    idle_steps(3);
    pulse_reset();
    idle_steps(10);

    // Load, shift right with 0, shift left with 1.
    step(1'b0, 3'b011, 8'b10011001, 1'b0, 1'b0);
    step(1'b0, 3'b001, '0, 1'b0, 1'b0);
    step(1'b0, 3'b010, '0, 1'b0, 1'b1);

    // Rotations, clear, reserved mode.
    step(1'b0, 3'b011, 8'b10011001, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b100, '0, 1'b1, 1'b1);
    step(1'b0, 3'b101, '0, 1'b0, 1'b0);
    step(1'b0, 3'b110, '0, 1'b0, 1'b0);
    step(1'b0, 3'b011, 8'h6E, 1'b0, 1'b0);
    step(1'b0, 3'b111, 8'hFF, 1'b1, 1'b1);

    // Transfer of A5, full frame plus done and idle tail.
    step(1'b1, 3'b000, 8'hA5, 1'b0, 1'b0);
    idle_steps(10);

    // start and clear while busy are ignored; restart in the done cycle.
    step(1'b1, 3'b000, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 3'b110, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 3'b110, '0, 1'b0, 1'b1);
    step(1'b1, 3'b000, 8'h3C, 1'b0, 1'b1);
    idle_steps(10);

    // start and load in the same cycle: start wins.
    step(1'b1, 3'b011, 8'hE7, 1'b1, 1'b1);
    idle_steps(10);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) pulse_reset();
      else step(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                W'($urandom), 1'($urandom), 1'($urandom));
    end
    idle_steps(12);

    // Let the monitor drain the queue, then confirm it is empty.
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
